// File: rtl/truth_table_sweep_ctrl_if.sv
// Handshake and stimulus/result bundle between a sweep requester and truth_table_sweep_ctrl.
// master = requester plus circuit under test, slave = the sweep controller.
interface truth_table_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic        dut_out;
    logic        in1;
    logic        in2;
    logic        in3;
    logic        in4;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] captured;
    logic [15:0] mismatch;

    modport master (
        output start, abort, dut_out,
        input  in1, in2, in3, in4, busy, done, pass, captured, mismatch
    );

    modport slave (
        input  start, abort, dut_out,
        output in1, in2, in3, in4, busy, done, pass, captured, mismatch
    );
endinterface

// File: rtl/truth_table_sweep_ctrl.sv
// Walks a 4-input circuit through all 16 input codes, samples its output after a settle
// interval and compares against TRUTH_TABLE. Define SWEEP_EARLY_STOP_EN to end on first mismatch.
module truth_table_sweep_ctrl #(
    parameter logic [15:0] TRUTH_TABLE   = 16'h5215,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          CNT_W         = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    truth_table_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      cap_q, cap_d;
    logic [15:0]      mm_q, mm_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sample_err;
    logic             stop_early;

    // NOTE: non-blocking assignments here so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        mm_d       = mm_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sample_err = bus.dut_out ^ TRUTH_TABLE[k_q];
`ifdef SWEEP_EARLY_STOP_EN
        stop_early = sample_err;
`else
        stop_early = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETTLE;
                    k_d     = '0;
                    cnt_d   = CNT_RELOAD;
                    cap_d   = '0;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    k_d     = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                // Abort outranks the final sample: partial results stay, no done pulse.
                if (bus.abort) begin
                    state_d = IDLE;
                    k_d     = '0;
                    busy_d  = 1'b0;
                end else begin
                    cap_d[k_q] = bus.dut_out;
                    mm_d[k_q]  = sample_err;
                    if (k_q == 4'd15 || stop_early) begin
                        state_d = DONE;
                        k_d     = '0;
                        done_d  = 1'b1;
                        pass_d  = (mm_d == 16'h0000);
                    end else begin
                        state_d = SETTLE;
                        k_d     = k_q + 4'd1;
                        cnt_d   = CNT_RELOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.in1      = k_q[3];
    assign bus.in2      = k_q[2];
    assign bus.in3      = k_q[1];
    assign bus.in4      = k_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.captured = cap_q;
    assign bus.mismatch = mm_q;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Directed bench for truth_table_sweep_ctrl: vector table of circuit faults plus abort,
// reset, held-start and fast-settle sequences. Cycle 1 is the cycle right after the start edge.
module tb_truth_table_sweep_ctrl;

    localparam logic [15:0] TT = 16'h5215;

    typedef struct {
        string       name;
        int          mode;
        logic [15:0] cap;
        logic [15:0] mm;
        logic        pass;
        int          cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;
    logic [3:0] idx, fidx;
    vec_t vecs[5];

    always #5 clk = ~clk;

    truth_table_sweep_ctrl_if bus ();
    truth_table_sweep_ctrl_if fbus ();

    truth_table_sweep_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    truth_table_sweep_ctrl #(.SETTLE_CYCLES(1)) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fbus.slave)
    );

    // Circuit-under-test models: 0 correct, 1 stuck-0, 2 stuck-1, 3 index 9 wrong, 4 inverted.
    function automatic logic circuit(int m, logic [3:0] i);
        logic [15:0] t;
        t = TT;
        case (m)
            0:       return t[i];
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return t[i] ^ (i == 4'd9);
            default: return ~t[i];
        endcase
    endfunction

    assign idx  = {bus.in1, bus.in2, bus.in3, bus.in4};
    assign fidx = {fbus.in1, fbus.in2, fbus.in3, fbus.in4};
    assign bus.dut_out  = circuit(mode, idx);
    assign fbus.dut_out = circuit(0, fidx);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1.
    task automatic start_sweep();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (bus.done !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", bus.done, 1);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_captured"}, bus.captured, 0);
        check({tag, "_mismatch"}, bus.mismatch, 0);
        check({tag, "_stim"}, idx, 0);
    endtask

    initial begin
        int c;
        int errs;
        int done_cnt;

        vecs[0] = '{"correct",  0, 16'h5215, 16'h0000, 1'b1, 81};
`ifdef SWEEP_EARLY_STOP_EN
        vecs[1] = '{"stuck0",   1, 16'h0000, 16'h0001, 1'b0,  6};
        vecs[2] = '{"stuck1",   2, 16'h0003, 16'h0002, 1'b0, 11};
        vecs[3] = '{"bad_idx9", 3, 16'h0015, 16'h0200, 1'b0, 51};
        vecs[4] = '{"inverted", 4, 16'h0000, 16'h0001, 1'b0,  6};
`else
        vecs[1] = '{"stuck0",   1, 16'h0000, 16'h5215, 1'b0, 81};
        vecs[2] = '{"stuck1",   2, 16'hFFFF, 16'hADEA, 1'b0, 81};
        vecs[3] = '{"bad_idx9", 3, 16'h5015, 16'h0200, 1'b0, 81};
        vecs[4] = '{"inverted", 4, 16'hADEA, 16'hFFFF, 1'b0, 81};
`endif

        bus.start = 1'b0;
        bus.abort = 1'b0;
        fbus.start = 1'b0;
        fbus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Fast-settle instance: index k visible in cycles 2k+1 and 2k+2, done in cycle 33.
        @(negedge clk);
        fbus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fbus.start = 1'b0;
        errs = 0;
        for (int cy = 1; cy <= 32; cy++) begin
            if (int'(fidx) != (cy - 1) / 2 || fbus.done !== 1'b0 || fbus.busy !== 1'b1) errs++;
            @(negedge clk);
        end
        check("fast_step_order_errs", errs, 0);
        check("fast_done_c33", fbus.done, 1);
        check("fast_pass", fbus.pass, 1);
        check("fast_captured", fbus.captured, 16'h5215);

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            start_sweep();
            wait_done(c);
            check({vecs[i].name, "_cycles"}, c, vecs[i].cycles);
            check({vecs[i].name, "_captured"}, bus.captured, vecs[i].cap);
            check({vecs[i].name, "_mismatch"}, bus.mismatch, vecs[i].mm);
            check({vecs[i].name, "_pass"}, bus.pass, vecs[i].pass);
            check({vecs[i].name, "_busy_in_done"}, bus.busy, 1);
            check({vecs[i].name, "_stim_in_done"}, idx, 0);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, bus.done, 0);
            check({vecs[i].name, "_busy_after"}, bus.busy, 0);
            check({vecs[i].name, "_pass_hold"}, bus.pass, vecs[i].pass);
        end

        // start held high: no restart mid-sweep, second sweep accepted the edge after busy falls.
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(c);
        check("held_cycles", c, 81);
        check("held_pass", bus.pass, 1);
        @(negedge clk);
        check("held_busy_low", bus.busy, 0);
        @(negedge clk);
        check("held_restart_busy", bus.busy, 1);
        check("held_restart_pass_clr", bus.pass, 0);
        check("held_restart_cap_clr", bus.captured, 0);
        bus.start = 1'b0;

        // Reset in the middle of that second sweep.
        repeat (30) @(negedge clk);
        check("mid_sweep_stim_nonzero", idx != 4'd0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("mid_reset");
        rst_n = 1'b1;

        // Abort while index 7 settles.
        start_sweep();
        c = 0;
        while (idx != 4'd7 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("reach_idx7", idx, 7);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort7_busy", bus.busy, 0);
        check("abort7_done", bus.done, 0);
        check("abort7_pass", bus.pass, 0);
        check("abort7_stim", idx, 0);
        check("abort7_captured", bus.captured, 16'h0015);
        check("abort7_mismatch", bus.mismatch, 0);
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        check("abort7_stays_idle", done_cnt, 0);

        // Abort coinciding with the index-15 sample (cycle 80).
        start_sweep();
        repeat (79) @(negedge clk);
        check("c80_stim_idx15", idx, 15);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort15_done", bus.done, 0);
        check("abort15_busy", bus.busy, 0);
        check("abort15_pass", bus.pass, 0);
        check("abort15_captured", bus.captured, 16'h5215);
        check("abort15_mismatch", bus.mismatch, 0);

        // start and abort together in IDLE: the sweep starts.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", bus.busy, 1);
        wait_done(c);
        check("start_abort_cycles", c, 81);
        check("start_abort_pass", bus.pass, 1);

        // abort in DONE and IDLE has no effect; results hold.
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_done_ignored_pass", bus.pass, 1);
        repeat (3) @(negedge clk);
        bus.abort = 1'b0;
        check("abort_idle_busy", bus.busy, 0);
        check("abort_idle_captured", bus.captured, 16'h5215);
        check("abort_idle_pass", bus.pass, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep_ctrl.md
# truth_table_sweep_ctrl

Sequencer that exercises one 4-input combinational logic circuit (NOR/NOT netlist, single output) across all 16 input combinations. For each combination it drives the stimulus, waits a programmable settle interval, samples the circuit output and compares it against an expected truth table. Sits beside the circuit under test in characterisation and self-check builds, and reports the captured truth table, a mismatch mask and pass/fail.

## Interface

- TRUTH_TABLE, 16'h5215, expected output; bit k is the expected `out` for combination index k
- SETTLE_CYCLES, 4, cycles each stimulus is held before sampling; legal range 1..255
- CNT_W, 8, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  cancel a sweep in progress
- dut_out  in  1  output of the circuit under test
- in1  out  1  stimulus bit, index bit 3 (MSB)
- in2  out  1  stimulus bit, index bit 2
- in3  out  1  stimulus bit, index bit 1
- in4  out  1  stimulus bit, index bit 0 (LSB)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep completed
- pass  out  1  last completed sweep matched TRUTH_TABLE
- captured  out  16  sampled `dut_out` per index, bit k = index k
- mismatch  out  16  captured XOR TRUTH_TABLE, restricted to sampled indices

## Operation

- Index k = {in1,in2,in3,in4}. Sweep order: k = 0,1,…,15.
- States:
  - IDLE: stimulus = 0. `start`=1 → SETTLE. On entry, clear `captured` and `mismatch`, set k=0, load counter = SETTLE_CYCLES−1, clear `pass`.
  - SETTLE: decrement the counter. At 0 → SAMPLE.
  - SAMPLE: `captured[k]` ← `dut_out`, `mismatch[k]` ← `dut_out` ^ TRUTH_TABLE[k]. If k=15 → DONE. Otherwise k ← k+1, reload the counter, → SETTLE.
  - DONE: for one cycle, `done`=1 and `pass` ← (mismatch==0) → IDLE.
- `busy`=1 in SETTLE, SAMPLE and DONE.
- `start` outside IDLE is ignored. There is no queueing.
- `abort`=1 in SETTLE or SAMPLE → IDLE next cycle. Stimulus returns to 0. No `done`, `pass` stays 0, and partial `captured`/`mismatch` are retained. If `abort` and the k=15 sample coincide, abort wins (no `done`). `abort` in IDLE or DONE has no effect.
- `start` and `abort` together in IDLE: the sweep starts.
- Outputs `captured`, `mismatch` and `pass` hold their values until the next accepted `start`.

## Timing

- All outputs are registered. Reset values: in1..in4=0, busy=0, done=0, pass=0, captured=0, mismatch=0, state IDLE.
- `rst_n` low on any edge forces the reset values regardless of state. A sweep interrupted by reset is lost.
- Let `start` be sampled at edge E0. Stimulus index 0 is visible after E0.
- Index k is held for SETTLE_CYCLES+1 cycles. `dut_out` is sampled at edge E0 + (k+1)(SETTLE_CYCLES+1). The stimulus changes to k+1 at that same edge.
- `done` is high in the cycle after the index-15 sample. Total from E0 to the `done` assertion edge: 16·(SETTLE_CYCLES+1)+1 cycles (81 at default).
- `busy` falls at the edge `done` falls. A new `start` is accepted on the following edge.
- `dut_out` is treated as synchronous to `clk`. The settle interval absorbs circuit propagation.

## Configuration

- SWEEP_EARLY_STOP_EN defined:
  - A SAMPLE with a mismatch goes straight to DONE.
  - `done` pulses with `pass`=0. `captured`/`mismatch` hold indices 0..k only; higher bits are 0.
  - The stimulus returns to 0.
- Undefined: all 16 indices are always swept (behaviour above).

## Test plan

- Reset, then a default sweep against a correct 0x5215 model: `done` after 81 cycles, captured=16'h5215, mismatch=16'h0000, pass=1.
- `dut_out` stuck at 0: captured=16'h0000, mismatch=16'h5215, pass=0.
  - With SWEEP_EARLY_STOP_EN: `done` after index 0 (bit0 expected 1), i.e. 1·5+1=6 cycles, mismatch=16'h0001.
- SETTLE_CYCLES=1, correct model: stimulus steps every 2 cycles in order 0..15, `done` at cycle 33, pass=1.
- `abort` during index 7: IDLE next cycle, no `done`, busy=0, pass=0, captured bits 7..15 = 0, stimulus = 0.
- `start` held high during a sweep: no restart. The second sweep begins on the edge after `busy` falls. `rst_n` low mid-sweep: all outputs at reset values the next cycle.
